xor_session_ctrl: RTL and testbench

Sequencer for the serial XOR-encryption datapath. It owns the shared serial input pin and decides when the key deserializer and the message deserializer capture bits by driving their load-flag windows. It then starts the XOR stage, hands the ciphertext to the serializer, and tracks which key byte is applied to each message. It sits between the top-level pins and the deserializer → xor_encrypt → serializer chain, replacing manual flag driving.

---
 rtl/xor_session_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_xor_session_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_session_ctrl.sv
// xor_session_ctrl
//   Sequencer for the serial XOR-encryption datapath. It opens the load windows
//   for the key and message deserializers on the shared serial pin. It then
//   starts the XOR stage and hands the result to the serializer. It also tracks
//   which key slice each message uses.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   ena                 global enable; low freezes all state and gates pulses/flags
//   iStart, iLoad_key   transaction request (sampled in IDLE) and key-load select
//   oKey_flag           key deserializer load window
//   oMsg_flag           message deserializer load window
//   oKey_byte_sel       key slice index used by the XOR stage
//   oEnc_start/iEnc_done  XOR stage handshake
//   oSer_start/iSer_done  serializer handshake
//   oBusy               state is not IDLE
//   oKey_valid          a full key has been loaded since reset
//   oError              sticky error (bad request, start while busy, timeout)
//   oMsg_count          messages completed since the last key load, saturating
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | waiting for iStart
// S_LOAD_KEY | key window open, KEY_SIZE enabled cycles
// S_LOAD_MSG | message window open, MSG_SIZE enabled cycles
// S_ENCRYPT  | XOR stage started, waiting for iEnc_done or timeout
// S_SERIALIZE| serializer started, waiting for iSer_done or timeout
module xor_session_ctrl #(
  parameter int KEY_SIZE = 32,
  parameter int MSG_SIZE = 8,
  parameter int TIMEOUT  = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   ena,
  input  logic                                   iStart,
  input  logic                                   iLoad_key,
  output logic                                   oKey_flag,
  output logic                                   oMsg_flag,
  output logic [$clog2(KEY_SIZE/MSG_SIZE)-1:0]   oKey_byte_sel,
  output logic                                   oEnc_start,
  input  logic                                   iEnc_done,
  output logic                                   oSer_start,
  input  logic                                   iSer_done,
  output logic                                   oBusy,
  output logic                                   oKey_valid,
  output logic                                   oError,
  output logic [7:0]                             oMsg_count
);

  localparam int RATIO  = KEY_SIZE / MSG_SIZE;
  localparam int SEL_W  = $clog2(RATIO);
  localparam int BIT_W  = $clog2(KEY_SIZE + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [BIT_W-1:0]  KEY_LAST  = BIT_W'(KEY_SIZE - 1);
  localparam logic [BIT_W-1:0]  MSG_LAST  = BIT_W'(MSG_SIZE - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(RATIO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_KEY,
    S_LOAD_MSG,
    S_ENCRYPT,
    S_SERIALIZE
  } state_t;

  state_t              state_q, state_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                pend_q, pend_d;
  logic                key_flag_q, key_flag_d;
  logic                msg_flag_q, msg_flag_d;
  logic                enc_start_q, enc_start_d;
  logic                ser_start_q, ser_start_d;
  logic                busy_q, busy_d;
  logic                key_valid_q, key_valid_d;
  logic                error_q, error_d;
  logic [7:0]          msg_count_q, msg_count_d;
  logic [SEL_W-1:0]    sel_q, sel_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      pend_q      <= 1'b0;
      key_flag_q  <= 1'b0;
      msg_flag_q  <= 1'b0;
      enc_start_q <= 1'b0;
      ser_start_q <= 1'b0;
      busy_q      <= 1'b0;
      key_valid_q <= 1'b0;
      error_q     <= 1'b0;
      msg_count_q <= '0;
      sel_q       <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      pend_q      <= pend_d;
      key_flag_q  <= key_flag_d;
      msg_flag_q  <= msg_flag_d;
      enc_start_q <= enc_start_d;
      ser_start_q <= ser_start_d;
      busy_q      <= busy_d;
      key_valid_q <= key_valid_d;
      error_q     <= error_d;
      msg_count_q <= msg_count_d;
      sel_q       <= sel_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    pend_d      = pend_q;
    key_valid_d = key_valid_q;
    error_d     = error_q;
    msg_count_d = msg_count_q;
    sel_d       = sel_q;
    key_flag_d  = 1'b0;
    msg_flag_d  = 1'b0;
    enc_start_d = 1'b0;
    ser_start_d = 1'b0;

    if (ena) begin
      case (state_q)
        S_IDLE: begin
          if (iStart) begin
            if (iLoad_key) begin
              state_d   = S_LOAD_KEY;
              bit_cnt_d = '0;
              error_d   = 1'b0;
            end else if (key_valid_q) begin
              state_d   = S_LOAD_MSG;
              bit_cnt_d = '0;
              error_d   = 1'b0;
            end else begin
              error_d = 1'b1;
            end
          end
        end

        S_LOAD_KEY: begin
          if (bit_cnt_q == KEY_LAST) begin
            state_d     = S_LOAD_MSG;
            bit_cnt_d   = '0;
            key_valid_d = 1'b1;
            msg_count_d = '0;
            sel_d       = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end

        S_LOAD_MSG: begin
          if (bit_cnt_q == MSG_LAST) begin
            state_d    = S_ENCRYPT;
            bit_cnt_d  = '0;
            wait_cnt_d = '0;
            pend_d     = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end

        S_ENCRYPT: begin
          // The start pulse counts as delivered only on an enabled edge;
          // otherwise it is re-issued once ena returns.
          if (enc_start_q) pend_d = 1'b0;
          if (iEnc_done) begin
            state_d    = S_SERIALIZE;
            wait_cnt_d = '0;
            pend_d     = 1'b1;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_d    = S_IDLE;
            wait_cnt_d = '0;
            pend_d     = 1'b0;
            error_d    = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end

        S_SERIALIZE: begin
          if (ser_start_q) pend_d = 1'b0;
          if (iSer_done) begin
            state_d     = S_IDLE;
            wait_cnt_d  = '0;
            pend_d      = 1'b0;
            msg_count_d = (msg_count_q == 8'hFF) ? msg_count_q : msg_count_q + 8'd1;
            sel_d       = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_d    = S_IDLE;
            wait_cnt_d = '0;
            pend_d     = 1'b0;
            error_d    = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase

      if (iStart && (state_q != S_IDLE)) error_d = 1'b1;

      key_flag_d  = (state_d == S_LOAD_KEY);
      msg_flag_d  = (state_d == S_LOAD_MSG);
      enc_start_d = (state_d == S_ENCRYPT) && pend_d;
      ser_start_d = (state_d == S_SERIALIZE) && pend_d;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign oKey_flag     = key_flag_q;
  assign oMsg_flag     = msg_flag_q;
  assign oEnc_start    = enc_start_q;
  assign oSer_start    = ser_start_q;
  assign oBusy         = busy_q;
  assign oKey_valid    = key_valid_q;
  assign oError        = error_q;
  assign oMsg_count    = msg_count_q;
  assign oKey_byte_sel = sel_q;

endmodule

// File: tb/tb_xor_session_ctrl.sv
module tb_xor_session_ctrl;
  localparam int KEY_SIZE = 32;
  localparam int MSG_SIZE = 8;
  localparam int TIMEOUT  = 64;
  localparam int RATIO    = KEY_SIZE / MSG_SIZE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic       iStart = 1'b0;
  logic       iLoad_key = 1'b0;
  logic       iEnc_done = 1'b0;
  logic       iSer_done = 1'b0;
  logic       oKey_flag, oMsg_flag, oEnc_start, oSer_start, oBusy, oKey_valid, oError;
  logic [1:0] oKey_byte_sel;
  logic [7:0] oMsg_count;

  int checks = 0;
  int errors = 0;

  // reference model: transaction-level bookkeeping
  bit m_key_valid = 0;
  bit m_error = 0;
  int m_count = 0;
  int m_sel = 0;

  always #5 clk = ~clk;

  xor_session_ctrl #(.KEY_SIZE(KEY_SIZE), .MSG_SIZE(MSG_SIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ena(ena), .iStart(iStart), .iLoad_key(iLoad_key),
    .oKey_flag(oKey_flag), .oMsg_flag(oMsg_flag), .oKey_byte_sel(oKey_byte_sel),
    .oEnc_start(oEnc_start), .iEnc_done(iEnc_done), .oSer_start(oSer_start),
    .iSer_done(iSer_done), .oBusy(oBusy), .oKey_valid(oKey_valid), .oError(oError),
    .oMsg_count(oMsg_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_complete();
    if (m_count < 255) m_count++;
    m_sel = (m_sel + 1) % RATIO;
  endtask

  // Precondition: sampled in the cycle where oEnc_start is high.
  task automatic run_crypto(input int d_enc, input int d_ser);
    for (int i = 0; i < d_enc; i++) begin
      iSer_done = 1'($urandom % 2);
      step();
      checks++;
      if (oBusy !== 1'b1 || oSer_start !== 1'b0) begin
        errors++;
        $display("FAIL enc_wait busy=%b ser_start=%b expected busy=1 ser_start=0", oBusy, oSer_start);
      end
    end
    iEnc_done = 1'b1;
    iSer_done = 1'($urandom % 2);
    step();
    iEnc_done = 1'b0;
    iSer_done = 1'b0;
    checks++;
    if (oSer_start !== 1'b1) begin
      errors++;
      $display("FAIL ser_start got %b expected 1", oSer_start);
    end
    for (int i = 0; i < d_ser; i++) begin
      iEnc_done = 1'($urandom % 2);
      step();
      checks++;
      if (oBusy !== 1'b1 || oSer_start !== 1'b0) begin
        errors++;
        $display("FAIL ser_wait busy=%b ser_start=%b expected busy=1 ser_start=0", oBusy, oSer_start);
      end
    end
    iEnc_done = 1'b0;
    iSer_done = 1'b1;
    step();
    iSer_done = 1'b0;
    model_complete();
    checks++;
    if (oBusy !== 1'b0) begin
      errors++;
      $display("FAIL done_busy got %b expected 0", oBusy);
    end
    checks++;
    if (oMsg_count !== 8'(m_count)) begin
      errors++;
      $display("FAIL msg_count got %0d expected %0d", oMsg_count, m_count);
    end
    checks++;
    if (oKey_byte_sel !== 2'(m_sel)) begin
      errors++;
      $display("FAIL byte_sel got %0d expected %0d", oKey_byte_sel, m_sel);
    end
    checks++;
    if (oError !== m_error) begin
      errors++;
      $display("FAIL error_flag got %b expected %b", oError, m_error);
    end
  endtask

  // Key+message load; leaves the bench in the oEnc_start cycle.
  task automatic key_load(input int inject_at);
    logic ek, em, ee;
    iStart = 1'b1;
    iLoad_key = 1'b1;
    step();
    iStart = 1'b0;
    iLoad_key = 1'($urandom % 2);
    m_error = 0;
    checks++;
    if (oError !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_key got %b expected 0", oError);
    end
    for (int c = 1; c <= KEY_SIZE + MSG_SIZE + 1; c++) begin
      ek = (c <= KEY_SIZE);
      em = (c > KEY_SIZE) && (c <= KEY_SIZE + MSG_SIZE);
      ee = (c == KEY_SIZE + MSG_SIZE + 1);
      checks++;
      if ({oKey_flag, oMsg_flag, oEnc_start, oBusy} !== {ek, em, ee, 1'b1}) begin
        errors++;
        $display("FAIL key_window cycle %0d got key/msg/enc/busy=%b%b%b%b expected %b%b%b1",
                 c, oKey_flag, oMsg_flag, oEnc_start, oBusy, ek, em, ee);
      end
      if (c == inject_at) iStart = 1'b1;
      if (c <= KEY_SIZE + MSG_SIZE) begin
        step();
        if (iStart) m_error = 1;
        iStart = 1'b0;
      end
    end
    iLoad_key = 1'b0;
    m_key_valid = 1;
    m_count = 0;
    m_sel = 0;
    checks++;
    if (oKey_valid !== 1'b1 || oError !== m_error) begin
      errors++;
      $display("FAIL key_valid got valid=%b err=%b expected valid=1 err=%b", oKey_valid, oError, m_error);
    end
  endtask

  // Message-only load; leaves the bench in the oEnc_start cycle.
  task automatic msg_load();
    logic em, ee;
    iStart = 1'b1;
    iLoad_key = 1'b0;
    step();
    iStart = 1'b0;
    m_error = 0;
    checks++;
    if (oError !== 1'b0 || oBusy !== 1'b1) begin
      errors++;
      $display("FAIL msg_accept err=%b busy=%b expected err=0 busy=1", oError, oBusy);
    end
    for (int c = 1; c <= MSG_SIZE + 1; c++) begin
      em = (c <= MSG_SIZE);
      ee = (c == MSG_SIZE + 1);
      checks++;
      if ({oKey_flag, oMsg_flag, oEnc_start} !== {1'b0, em, ee}) begin
        errors++;
        $display("FAIL msg_window cycle %0d got key/msg/enc=%b%b%b expected 0%b%b",
                 c, oKey_flag, oMsg_flag, oEnc_start, em, ee);
      end
      if (c <= MSG_SIZE) begin
        iEnc_done = 1'($urandom % 2);
        iSer_done = 1'($urandom % 2);
        step();
      end
    end
    iEnc_done = 1'b0;
    iSer_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ena = 1'b1;
    step();
    step();
    checks++;
    if ({oKey_flag, oMsg_flag, oEnc_start, oSer_start, oBusy, oKey_valid, oError} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %b expected 0000000",
               {oKey_flag, oMsg_flag, oEnc_start, oSer_start, oBusy, oKey_valid, oError});
    end
    checks++;
    if (oKey_byte_sel !== 2'd0 || oMsg_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_regs sel=%0d count=%0d expected 0 0", oKey_byte_sel, oMsg_count);
    end
    #2 rst = 1'b0;
    step();
    checks++;
    if (oBusy !== 1'b0 || oKey_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset busy=%b valid=%b expected 0 0", oBusy, oKey_valid);
    end
  endtask

  task automatic test_no_key();
    iStart = 1'b1;
    iLoad_key = 1'b0;
    step();
    iStart = 1'b0;
    m_error = 1;
    checks++;
    if (oError !== 1'b1 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL no_key err=%b busy=%b expected err=1 busy=0", oError, oBusy);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({oKey_flag, oMsg_flag, oBusy} !== 3'b000) begin
        errors++;
        $display("FAIL no_key_idle key/msg/busy=%b%b%b expected 000", oKey_flag, oMsg_flag, oBusy);
      end
    end
  endtask

  task automatic test_key_load();
    key_load(0);
    run_crypto(3, 3);
  endtask

  task automatic test_msg_seq();
    int exp_sel[5] = '{0, 1, 2, 3, 0};
    for (int t = 0; t < 5; t++) begin
      if (t == 0) key_load(0);
      else msg_load();
      checks++;
      if (oKey_byte_sel !== 2'(exp_sel[t])) begin
        errors++;
        $display("FAIL sel_seq txn %0d got %0d expected %0d", t, oKey_byte_sel, exp_sel[t]);
      end
      run_crypto(3, 3);
    end
    checks++;
    if (oMsg_count !== 8'd5) begin
      errors++;
      $display("FAIL seq_count got %0d expected 5", oMsg_count);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      if ($urandom % 4 == 0) key_load(0);
      else msg_load();
      run_crypto(int'($urandom_range(0, 12)), int'($urandom_range(0, 12)));
    end
  endtask

  task automatic test_timeout();
    msg_load();
    for (int i = 1; i < TIMEOUT; i++) begin
      iSer_done = 1'($urandom % 2);
      step();
    end
    checks++;
    if (oBusy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early busy=%b expected 1", oBusy);
    end
    step();
    iSer_done = 1'b0;
    m_error = 1;
    checks++;
    if (oBusy !== 1'b0 || oError !== 1'b1) begin
      errors++;
      $display("FAIL timeout busy=%b err=%b expected busy=0 err=1", oBusy, oError);
    end
    checks++;
    if (oMsg_count !== 8'(m_count) || oKey_byte_sel !== 2'(m_sel) || oKey_valid !== 1'b1) begin
      errors++;
      $display("FAIL timeout_keep count=%0d sel=%0d valid=%b expected %0d %0d 1",
               oMsg_count, oKey_byte_sel, oKey_valid, m_count, m_sel);
    end
    msg_load();
    run_crypto(1, 0);
  endtask

  task automatic test_ena_gap();
    int khigh = 0;
    int edges = 0;
    bit seen = 0;
    iStart = 1'b1;
    iLoad_key = 1'b1;
    step();
    iStart = 1'b0;
    iLoad_key = 1'b0;
    m_error = 0;
    khigh += int'(oKey_flag);
    for (int i = 0; i < 12; i++) begin
      step();
      khigh += int'(oKey_flag);
    end
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (oKey_flag !== 1'b0 || oBusy !== 1'b1) begin
        errors++;
        $display("FAIL gap_flag key=%b busy=%b expected key=0 busy=1", oKey_flag, oBusy);
      end
    end
    ena = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      edges++;
      if (oMsg_flag === 1'b1) seen = 1;
      else khigh += int'(oKey_flag);
    end
    checks++;
    if (edges !== 20) begin
      errors++;
      $display("FAIL gap_resume_cycles got %0d expected 20", edges);
    end
    checks++;
    if (khigh !== KEY_SIZE) begin
      errors++;
      $display("FAIL gap_key_total got %0d expected %0d", khigh, KEY_SIZE);
    end
    for (int i = 0; i < MSG_SIZE; i++) step();
    checks++;
    if (oEnc_start !== 1'b1) begin
      errors++;
      $display("FAIL gap_enc_start got %b expected 1", oEnc_start);
    end
    m_key_valid = 1;
    m_count = 0;
    m_sel = 0;
    run_crypto(2, 2);
  endtask

  task automatic test_reset_mid();
    iStart = 1'b1;
    iLoad_key = 1'b0;
    step();
    iStart = 1'b0;
    for (int i = 0; i < 3; i++) step();
    #2 rst = 1'b1;
    #1;
    m_key_valid = 0;
    m_error = 0;
    m_count = 0;
    m_sel = 0;
    checks++;
    if ({oKey_flag, oMsg_flag, oEnc_start, oSer_start, oBusy, oKey_valid, oError} !== 7'b0 ||
        oKey_byte_sel !== 2'd0 || oMsg_count !== 8'd0) begin
      errors++;
      $display("FAIL async_reset flags=%b sel=%0d count=%0d expected all 0",
               {oKey_flag, oMsg_flag, oEnc_start, oSer_start, oBusy, oKey_valid, oError},
               oKey_byte_sel, oMsg_count);
    end
    #3 rst = 1'b0;
    step();
    checks++;
    if (oKey_valid !== 1'b0 || oBusy !== 1'b0 || oMsg_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold valid=%b busy=%b msg=%b expected 0 0 0", oKey_valid, oBusy, oMsg_flag);
    end
    key_load(15);
    run_crypto(4, 1);
  endtask

  initial begin
    test_reset();
    test_no_key();
    test_key_load();
    test_msg_seq();
    test_random();
    test_timeout();
    test_ena_gap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
